latch_write_arbiter: RTL and testbench
======================================

Name: latch_write_arbiter

Overview:
- Round-robin controller that shares one WIDTH-bit D-latch storage register among N_REQ requesters.
- It serialises write requests and drives the register's data and enable lines, holding enable for a fixed number of cycles.
- It returns a one-cycle ack to the requester that was served.
- It also issues a priority clear of the shared register. It sits between requester logic and the latch bank (d_latch_with_sr style cells).

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 8, data width of the shared register.
- HOLD_CYCLES, 2, cycles latch_en stays high per write (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester write request, level.
- wr_data  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- clr_req  in  1  request to clear the shared register; priority over req.
- ack  out  N_REQ  one-hot, one-cycle pulse to the served requester.
- latch_en  out  1  enable/gate to the latch bank.
- latch_d  out  WIDTH  data to the latch bank.
- latch_clr  out  1  reset line to the latch bank.
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- **Reset** (sync, on clk edge with reset=1):
  - state=IDLE; ack, latch_en, latch_d, latch_clr, grant_id, busy all = 0.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - Reset wins over every other event.
  - Reset mid-WRITE or mid-ACK aborts: latch_en drops and no ack is issued for the aborted transaction.
- **FSM states:** IDLE, CLEAR, WRITE, ACK.
- **IDLE:**
  - If clr_req=1, go to CLEAR. clr_req beats any req in the same cycle.
  - Else if req != 0, select the first requester with req high, searching from last_grant+1 upward with wrap-around.
  - On selection: grant_id <= i; latch_d <= wr_data slice i; hold counter <= HOLD_CYCLES; go to WRITE.
- **CLEAR:**
  - latch_clr=1 and latch_d=0 for exactly one cycle, then IDLE.
  - No ack is issued; last_grant is unchanged.
- **WRITE:**
  - latch_en=1 for exactly HOLD_CYCLES consecutive cycles.
  - latch_d and grant_id stay stable for the whole WRITE state.
  - The counter decrements each cycle; on the last cycle go to ACK.
- **ACK:**
  - ack[grant_id]=1 for one cycle; latch_en=0.
  - last_grant <= grant_id, then IDLE.
- **Latency:**
  - Request sampled in IDLE at edge k.
  - latch_en is high in cycles k+1 .. k+HOLD_CYCLES.
  - ack is high in cycle k+HOLD_CYCLES+1.
  - Next grant can start at edge k+HOLD_CYCLES+2.
- **Handshake:**
  - A requester keeps req high until it sees ack, then drops req.
  - req still high in the IDLE cycle after ack counts as a new request; round-robin order still applies.
  - req withdrawn during WRITE is ignored: the transaction completes and is acked.
  - wr_data changes after grant are ignored.
- **Deferral:** clr_req asserted during WRITE or ACK is not latched. It is acted on only if still high in IDLE.
- **Fairness:** with all requesters continuously requesting, each is served once per N_REQ transactions.
- **Outputs by state:**
  - busy is 0 only in IDLE.
  - latch_clr is 0 outside CLEAR.
  - grant_id holds its last value in IDLE.

Test Plan:
1. Reset held 3 cycles with req=4'b1111 and clr_req=1 -> all outputs 0, busy=0, no ack.
2. req=4'b0100, wr_data slice 2=8'hA5, HOLD_CYCLES=2 -> grant_id=2, latch_d=8'hA5 with latch_en high 2 cycles, ack=4'b0100 one cycle later, busy low the following cycle.
3. req=4'b1111 held, acks accepted -> ack order 0,1,2,3,0, each write with latch_en high 2 cycles and the matching data slice.
4. clr_req=1 and req=4'b0010 in the same IDLE cycle -> latch_clr=1 for 1 cycle with latch_d=0, then grant_id=1 write and ack=4'b0010.
5. reset pulsed during the 2nd latch_en cycle of a grant to requester 3 -> latch_en=0 next cycle, no ack, and the next request with req=4'b1001 grants requester 0.
6. req[1] dropped after the first WRITE cycle -> write still completes and ack[1] pulses; clr_req pulsed only during WRITE -> no CLEAR occurs.

Source files
------------

// File: rtl/latch_write_arbiter.sv
// Purpose  : round-robin writer that shares one WIDTH-bit latch register among N_REQ requesters.
// Latency  : request sampled at edge k -> latch_en in cycles k+1..k+HOLD_CYCLES, ack in k+HOLD_CYCLES+1.
// Backpress: requesters hold req (level) until their one-cycle ack; later requests simply wait in IDLE.
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   req          - per-requester level write request
//   wr_data      - requester i data in bits [i*WIDTH +: WIDTH]
//   clr_req      - clear request for the shared register, wins over req in IDLE only
//   ack          - one-hot, one-cycle acknowledge to the served requester
//   latch_en     - gate to the latch bank, high HOLD_CYCLES cycles per write
//   latch_d      - data to the latch bank (forced to zero during a clear)
//   latch_clr    - reset line to the latch bank, one cycle per clear
//   grant_id     - current or most recent granted requester
//   busy         - high whenever the controller is not idle
module latch_write_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wr_data,
    input  logic                       clr_req,
    output logic [N_REQ-1:0]           ack,
    output logic                       latch_en,
    output logic [WIDTH-1:0]           latch_d,
    output logic                       latch_clr,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WRITE = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     hold_cnt;
    logic [CW-1:0]     hold_cnt_nxt;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    last_grant_nxt;

    // next values of the registered outputs
    logic [N_REQ-1:0]  ack_nxt;
    logic              latch_en_nxt;
    logic [WIDTH-1:0]  latch_d_nxt;
    logic              latch_clr_nxt;
    logic [IDW-1:0]    grant_id_nxt;
    logic              busy_nxt;

    // round-robin pick
    logic              rr_found;
    logic [IDW-1:0]    rr_sel;
    logic [IDW-1:0]    rr_idx;

    // unpack the flat data bus so the granted slice is a plain array lookup
    logic [WIDTH-1:0]  slice [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slice[i] = wr_data[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just after the last served requester and wraps, so the
    // most recently served one is considered last.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = IDW'((int'(last_grant) + k) % N_REQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    // Next-state and next-output logic. Outputs are registered, so each
    // branch sets the value the output takes in the state being entered.
    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        last_grant_nxt = last_grant;
        ack_nxt        = '0;
        latch_en_nxt   = 1'b0;
        latch_d_nxt    = latch_d;
        latch_clr_nxt  = 1'b0;
        grant_id_nxt   = grant_id;

        case (state)
            S_IDLE: begin
                // clr_req is only looked at here; a pulse seen in WRITE/ACK is dropped
                if (clr_req) begin
                    state_nxt     = S_CLEAR;
                    latch_clr_nxt = 1'b1;
                    latch_d_nxt   = '0;
                end else if (rr_found) begin
                    state_nxt    = S_WRITE;
                    grant_id_nxt = rr_sel;
                    latch_d_nxt  = slice[rr_sel];
                    latch_en_nxt = 1'b1;
                    hold_cnt_nxt = CW'(HOLD_CYCLES);
                end
            end

            S_CLEAR: begin
                state_nxt = S_IDLE;
            end

            S_WRITE: begin
                // hold_cnt counts the enable cycles still to run, including this one
                hold_cnt_nxt = hold_cnt - 1'b1;
                if (hold_cnt == CW'(1)) begin
                    state_nxt         = S_ACK;
                    ack_nxt[grant_id] = 1'b1;
                end else begin
                    latch_en_nxt = 1'b1;
                end
            end

            S_ACK: begin
                state_nxt      = S_IDLE;
                last_grant_nxt = grant_id;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            last_grant <= IDW'(N_REQ - 1);
            ack        <= '0;
            latch_en   <= 1'b0;
            latch_d    <= '0;
            latch_clr  <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_grant <= last_grant_nxt;
            ack        <= ack_nxt;
            latch_en   <= latch_en_nxt;
            latch_d    <= latch_d_nxt;
            latch_clr  <= latch_clr_nxt;
            grant_id   <= grant_id_nxt;
            busy       <= busy_nxt;
        end
    end

    // Structural invariants of the controller.
    a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ack));

    a_en_clr_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(latch_en && latch_clr));

    a_busy_tracks_state: assert property (@(posedge clk) disable iff (reset)
        busy == (state != S_IDLE));

    a_ack_not_with_en: assert property (@(posedge clk) disable iff (reset)
        (ack != '0) |-> !latch_en);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Purpose  : scoreboard bench for latch_write_arbiter; expected latch/ack events queued with cycle stamps.
// Latency  : checks each event against the cycle it must appear in.
// Backpress: requesters follow the req-until-ack handshake.
module tb_latch_write_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    localparam int EV_WR  = 0;
    localparam int EV_CLR = 1;
    localparam int EV_ACK = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH-1:0]   wr_data;
    logic                     clr_req;
    logic [N_REQ-1:0]         ack;
    logic                     latch_en;
    logic [WIDTH-1:0]         latch_d;
    logic                     latch_clr;
    logic [1:0]               grant_id;
    logic                     busy;

    always #5 clk = ~clk;

    latch_write_arbiter #(
        .N_REQ       (N_REQ),
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .ack       (ack),
        .latch_en  (latch_en),
        .latch_d   (latch_d),
        .latch_clr (latch_clr),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        int kind;
        int stamp;
        int val;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int stamp, input int val, input int data);
        ev_t e;
        e.kind  = kind;
        e.stamp = stamp;
        e.val   = val;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // A grant sampled at edge k: HOLD enable cycles stamped k.., then the ack.
    task automatic push_write(input int id, input int d, input int k);
        for (int h = 0; h < HOLD; h++) push_ev(EV_WR, k + h, id, d);
        push_ev(EV_ACK, k + HOLD, 1 << id, 0);
    endtask

    task automatic observe(input int kind, input int val, input int data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event @cyc %0d: kind %0d val 0x%0h data 0x%0h, expected none",
                     cyc, kind, val, data);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind",  kind, e.kind);
            check("ev_cycle", cyc,  e.stamp);
            check("ev_val",   val,  e.val);
            check("ev_data",  data, e.data);
        end
    endtask

    // Monitor: samples just after each rising edge, independent of stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check("busy_vs_activity", busy, latch_en | latch_clr | (ack != '0));
                if (latch_clr)  observe(EV_CLR, 0, int'(latch_d));
                if (latch_en)   observe(EV_WR, int'(grant_id), int'(latch_d));
                if (ack != '0)  observe(EV_ACK, int'(ack), 0);
            end
        end
    end

    // Advance to the falling edge that follows rising edge n.
    task automatic tick_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin : stim
        int k;
        int k2;

        reset   = 1'b1;
        req     = 4'b1111;
        clr_req = 1'b1;
        wr_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // 1: reset held for 3 edges while req and clr_req are asserted
        repeat (3) @(negedge clk);
        check("rst_ack",       ack,       4'b0000);
        check("rst_latch_en",  latch_en,  1'b0);
        check("rst_latch_d",   latch_d,   8'h00);
        check("rst_latch_clr", latch_clr, 1'b0);
        check("rst_grant_id",  grant_id,  2'd0);
        check("rst_busy",      busy,      1'b0);
        reset   = 1'b0;
        req     = 4'b0000;
        clr_req = 1'b0;
        mon_en  = 1'b1;
        tick_to(cyc + 1);

        // 3: all requesting -> 0,1,2,3,0, one grant every HOLD+2 edges
        k   = cyc + 1;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            push_write(j % 4, 8'h11 * ((j % 4) + 1), k + (HOLD + 2) * j);
        end
        tick_to(k + (HOLD + 2) * 4 + HOLD);
        req = 4'b0000;
        tick_to(k + (HOLD + 2) * 5);

        // 2: single request from requester 2; data change after grant ignored
        wr_data[23:16] = 8'hA5;
        k   = cyc + 1;
        req = 4'b0100;
        push_write(2, 8'hA5, k);
        tick_to(k);
        wr_data[23:16] = 8'h00;
        tick_to(k + HOLD);
        req = 4'b0000;
        tick_to(k + HOLD + 1);
        check("busy_low_after_ack", busy, 1'b0);
        tick_to(k + HOLD + 2);

        // 4: clear and request in the same idle cycle -> clear first, then write
        k       = cyc + 1;
        clr_req = 1'b1;
        req     = 4'b0010;
        push_ev(EV_CLR, k, 0, 0);
        push_write(1, 8'h22, k + 2);
        tick_to(k);
        clr_req = 1'b0;
        tick_to(k + 2 + HOLD);
        req = 4'b0000;
        tick_to(k + 2 + HOLD + 2);

        // 5: reset during the 2nd enable cycle of a grant to requester 3
        k   = cyc + 1;
        req = 4'b1000;
        push_ev(EV_WR, k,     3, 8'h44);
        push_ev(EV_WR, k + 1, 3, 8'h44);
        tick_to(k + 1);
        reset = 1'b1;
        req   = 4'b0000;
        tick_to(k + 2);
        reset = 1'b0;
        check("abort_latch_en", latch_en, 1'b0);
        check("abort_ack",      ack,      4'b0000);
        check("abort_busy",     busy,     1'b0);
        check("abort_grant_id", grant_id, 2'd0);
        tick_to(k + 3);
        // after reset requester 0 has priority over 3; 3 follows
        k2  = cyc + 1;
        req = 4'b1001;
        push_write(0, 8'h11, k2);
        push_write(3, 8'h44, k2 + HOLD + 2);
        tick_to(k2 + HOLD);
        req = 4'b1000;
        tick_to(k2 + 2 * HOLD + 2);
        req = 4'b0000;
        tick_to(k2 + 2 * HOLD + 4);

        // 6: req withdrawn mid-write still acked; clr_req only during WRITE ignored
        k   = cyc + 1;
        req = 4'b0010;
        push_write(1, 8'h22, k);
        tick_to(k);
        clr_req = 1'b1;
        tick_to(k + 1);
        req = 4'b0000;
        tick_to(k + 2);
        clr_req = 1'b0;
        tick_to(k + 6);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
